mem_except_cp0: RTL and testbench

//  MEM-stage exception collector plus CP0 register subset (BadVAddr, Count, Compare, Status, Cause, EPC).

---
 rtl/mem_except_cp0_if.sv | 39 +++
 rtl/mem_except_cp0.sv | 182 ++++++++++++++++++
 tb/tb_mem_except_cp0.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_except_cp0_if.sv
// MEM-stage exception / CP0 bundle between the pipeline (master) and the collector (slave).
interface mem_except_cp0_if;
  logic        stallM;
  logic [31:0] pcM;
  logic        is_in_dsM;
  logic        adel_ifM;
  logic        riM;
  logic        syscallM;
  logic        breakM;
  logic        ovM;
  logic        eretM;
  logic        adelM;
  logic        adesM;
  logic [31:0] addrM;
  logic [5:0]  int_hw;
  logic        we_cp0;
  logic [4:0]  waddr;
  logic [4:0]  raddr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] excepttypeM;
  logic        flushM;
  logic [31:0] newpcM;
  logic [31:0] epc_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;

  modport master (
    output stallM, pcM, is_in_dsM, adel_ifM, riM, syscallM, breakM, ovM, eretM,
           adelM, adesM, addrM, int_hw, we_cp0, waddr, raddr, wdata,
    input  rdata, excepttypeM, flushM, newpcM, epc_o, status_o, cause_o
  );

  modport slave (
    input  stallM, pcM, is_in_dsM, adel_ifM, riM, syscallM, breakM, ovM, eretM,
           adelM, adesM, addrM, int_hw, we_cp0, waddr, raddr, wdata,
    output rdata, excepttypeM, flushM, newpcM, epc_o, status_o, cause_o
  );
endinterface

// File: rtl/mem_except_cp0.sv
// MEM-stage exception collector with the CP0 subset BadVAddr/Count/Compare/Status/Cause/EPC.
// Picks one exception by priority in the same cycle and commits CP0 state on the next edge.
module mem_except_cp0 #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input logic             clk,
  input logic             resetn,
  mem_except_cp0_if.slave bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  localparam logic [RW-1:0] REG_BADVADDR = 5'd8;
  localparam logic [RW-1:0] REG_COUNT    = 5'd9;
  localparam logic [RW-1:0] REG_COMPARE  = 5'd11;
  localparam logic [RW-1:0] REG_STATUS   = 5'd12;
  localparam logic [RW-1:0] REG_CAUSE    = 5'd13;
  localparam logic [RW-1:0] REG_EPC      = 5'd14;

  localparam logic [DW-1:0] EXC_INT  = 32'h0000_0001;
  localparam logic [DW-1:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [DW-1:0] EXC_ADES = 32'h0000_0005;
  localparam logic [DW-1:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [DW-1:0] EXC_BP   = 32'h0000_0009;
  localparam logic [DW-1:0] EXC_RI   = 32'h0000_000A;
  localparam logic [DW-1:0] EXC_OV   = 32'h0000_000C;
  localparam logic [DW-1:0] EXC_ERET = 32'h0000_000E;

  // architectural state
  logic [DW-1:0] badVAddr;
  logic [DW-1:0] count;
  logic [DW-1:0] compare;
  logic [DW-1:0] epc;
  logic [7:0]    statusIm;
  logic          statusExl;
  logic          statusIe;
  logic          causeBd;
  logic [5:0]    causeIpHw;
  logic [1:0]    causeIpSw;
  logic [4:0]    causeExc;
  logic          tick;
  logic          timerInt;

  // combinational decode
  logic [DW-1:0] statusReg;
  logic [DW-1:0] causeReg;
  logic          intPending;
  logic [DW-1:0] excCode;
  logic          badFromPc;
  logic          badFromAddr;
  logic          takeExc;
  logic          takeEret;
  logic          mtc0En;

  // Read-only Status bits keep their reset pattern (BEV lives there).
  assign statusReg = {STATUS_RST[31:16], statusIm, STATUS_RST[7:2], statusExl, statusIe};
  assign causeReg  = {causeBd, 15'd0, causeIpHw, causeIpSw, 1'b0, causeExc, 2'b00};

  assign intPending = statusIe & ~statusExl & (|(causeReg[15:8] & statusIm));

  // Priority select; stalled or bubble instructions never raise anything.
  always_comb begin
    excCode     = '0;
    badFromPc   = 1'b0;
    badFromAddr = 1'b0;
    if (!bus.stallM && (bus.pcM != '0)) begin
      if (intPending) begin
        excCode = EXC_INT;
      end else if (bus.adel_ifM) begin
        excCode   = EXC_ADEL;
        badFromPc = 1'b1;
      end else if (bus.riM) begin
        excCode = EXC_RI;
      end else if (bus.syscallM) begin
        excCode = EXC_SYS;
      end else if (bus.breakM) begin
        excCode = EXC_BP;
      end else if (bus.ovM) begin
        excCode = EXC_OV;
      end else if (bus.adelM) begin
        excCode     = EXC_ADEL;
        badFromAddr = 1'b1;
      end else if (bus.adesM) begin
        excCode     = EXC_ADES;
        badFromAddr = 1'b1;
      end else if (bus.eretM) begin
        excCode = EXC_ERET;
      end
    end
  end

  assign takeEret = (excCode == EXC_ERET);
  assign takeExc  = (excCode != '0) && !takeEret;
  // Any exception (ERET included) squashes a same-cycle MTC0.
  assign mtc0En   = bus.we_cp0 & ~bus.stallM & (excCode == '0);

  assign bus.excepttypeM = excCode;
  assign bus.flushM      = (excCode != '0);
  assign bus.newpcM      = takeEret ? epc : EXC_VECTOR;
  assign bus.epc_o       = epc;
  assign bus.status_o    = statusReg;
  assign bus.cause_o     = causeReg;

  // CP0 read port; unmapped register numbers read as zero.
  always_comb begin
    bus.rdata = '0;
    case (bus.raddr)
      REG_BADVADDR: bus.rdata = badVAddr;
      REG_COUNT:    bus.rdata = count;
      REG_COMPARE:  bus.rdata = compare;
      REG_STATUS:   bus.rdata = statusReg;
      REG_CAUSE:    bus.rdata = causeReg;
      REG_EPC:      bus.rdata = epc;
      default:      bus.rdata = '0;
    endcase
  end

  // Free-running timer, Compare match and interrupt-line sampling (run even when stalled).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick      <= 1'b0;
      count     <= '0;
      compare   <= '0;
      timerInt  <= 1'b0;
      causeIpHw <= '0;
    end else begin
      tick      <= ~tick;
      causeIpHw <= {timerInt | bus.int_hw[5], bus.int_hw[4:0]};
      if (mtc0En && (bus.waddr == REG_COUNT)) begin
        count <= bus.wdata;
      end else if (tick) begin
        count <= count + DW'(1);
      end
      if (mtc0En && (bus.waddr == REG_COMPARE)) begin
        compare  <= bus.wdata;
        timerInt <= 1'b0;
      end else if ((count == compare) && (compare != '0)) begin
        timerInt <= 1'b1;
      end
    end
  end

  // Exception / ERET commit, otherwise MTC0 to the writable fields.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badVAddr  <= '0;
      epc       <= '0;
      statusIm  <= STATUS_RST[15:8];
      statusExl <= STATUS_RST[1];
      statusIe  <= STATUS_RST[0];
      causeBd   <= 1'b0;
      causeIpSw <= '0;
      causeExc  <= '0;
    end else if (takeExc) begin
      epc       <= bus.is_in_dsM ? (bus.pcM - DW'(4)) : bus.pcM;
      causeBd   <= bus.is_in_dsM;
      causeExc  <= (excCode == EXC_INT) ? 5'd0 : excCode[4:0];
      statusExl <= 1'b1;
      if (badFromPc) begin
        badVAddr <= bus.pcM;
      end else if (badFromAddr) begin
        badVAddr <= bus.addrM;
      end
    end else if (takeEret) begin
      statusExl <= 1'b0;
    end else if (mtc0En) begin
      case (bus.waddr)
        REG_STATUS: begin
          statusIm  <= bus.wdata[15:8];
          statusExl <= bus.wdata[1];
          statusIe  <= bus.wdata[0];
        end
        REG_CAUSE: causeIpSw <= bus.wdata[9:8];
        REG_EPC:   epc       <= bus.wdata;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_except_cp0.sv
// Directed bench for mem_except_cp0: expectations queued at drive time, popped at sample time.
module tb_mem_except_cp0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic resetn;
  int   total;
  int   bad;
  exp_t sb[$];

  mem_except_cp0_if bus ();

  mem_except_cp0 dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic pushExp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic clearIn();
    bus.stallM    = 1'b0;
    bus.pcM       = '0;
    bus.is_in_dsM = 1'b0;
    bus.adel_ifM  = 1'b0;
    bus.riM       = 1'b0;
    bus.syscallM  = 1'b0;
    bus.breakM    = 1'b0;
    bus.ovM       = 1'b0;
    bus.eretM     = 1'b0;
    bus.adelM     = 1'b0;
    bus.adesM     = 1'b0;
    bus.addrM     = '0;
    bus.int_hw    = '0;
    bus.we_cp0    = 1'b0;
    bus.waddr     = '0;
    bus.raddr     = '0;
    bus.wdata     = '0;
  endtask

  task automatic edgeSample();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    clearIn();
    bus.we_cp0 = 1'b1;
    bus.waddr  = a;
    bus.wdata  = d;
    edgeSample();
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    resetn = 1'b0;
    clearIn();
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // reset values, then Count at half clock rate
    pushExp("rst_status", 32'h0040_0000);
    pushExp("rst_cause", 32'h0);
    pushExp("rst_epc", 32'h0);
    pushExp("rst_flush", 32'h0);
    #1;
    chk(bus.status_o);
    chk(bus.cause_o);
    chk(bus.epc_o);
    chk(32'(bus.flushM));
    bus.raddr = 5'd9;
    pushExp("count_6_edges", 32'd3);
    repeat (6) @(posedge clk);
    #1;
    chk(bus.rdata);

    // 1: data load address error, concurrent MTC0 EPC dropped
    @(negedge clk);
    clearIn();
    bus.adelM  = 1'b1;
    bus.addrM  = 32'h1000_0002;
    bus.pcM    = 32'hBFC0_0100;
    bus.we_cp0 = 1'b1;
    bus.waddr  = 5'd14;
    bus.wdata  = 32'hDEAD_BEEF;
    bus.raddr  = 5'd8;
    pushExp("t1_exc", 32'h4);
    pushExp("t1_flush", 32'h1);
    pushExp("t1_newpc", 32'hBFC0_0380);
    pushExp("t1_badvaddr", 32'h1000_0002);
    pushExp("t1_epc", 32'hBFC0_0100);
    pushExp("t1_exccode", 32'h4);
    pushExp("t1_exl", 32'h1);
    #1;
    chk(bus.excepttypeM);
    chk(32'(bus.flushM));
    chk(bus.newpcM);
    edgeSample();
    chk(bus.rdata);
    chk(bus.epc_o);
    chk(32'(bus.cause_o[6:2]));
    chk(32'(bus.status_o[1]));

    // 2: store address error in a delay slot
    @(negedge clk);
    clearIn();
    bus.adesM     = 1'b1;
    bus.is_in_dsM = 1'b1;
    bus.pcM       = 32'hBFC0_0204;
    bus.addrM     = 32'h2000_0001;
    bus.raddr     = 5'd8;
    pushExp("t2_exc", 32'h5);
    pushExp("t2_epc", 32'hBFC0_0200);
    pushExp("t2_bd", 32'h1);
    pushExp("t2_badvaddr", 32'h2000_0001);
    #1;
    chk(bus.excepttypeM);
    edgeSample();
    chk(bus.epc_o);
    chk(32'(bus.cause_o[31]));
    chk(bus.rdata);

    // 3: reserved instruction outranks adelM, BadVAddr untouched
    @(negedge clk);
    clearIn();
    bus.riM   = 1'b1;
    bus.adelM = 1'b1;
    bus.pcM   = 32'hBFC0_0300;
    bus.addrM = 32'h3000_0003;
    bus.raddr = 5'd8;
    pushExp("t3_exc", 32'hA);
    pushExp("t3_badvaddr", 32'h2000_0001);
    pushExp("t3_exccode", 32'hA);
    pushExp("t3_bd", 32'h0);
    #1;
    chk(bus.excepttypeM);
    edgeSample();
    chk(bus.rdata);
    chk(32'(bus.cause_o[6:2]));
    chk(32'(bus.cause_o[31]));

    // fetch address error outranks ri, BadVAddr takes pcM
    @(negedge clk);
    clearIn();
    bus.adel_ifM = 1'b1;
    bus.riM      = 1'b1;
    bus.pcM      = 32'hBFC0_0102;
    bus.addrM    = 32'h5555_5555;
    bus.raddr    = 5'd8;
    pushExp("adelif_exc", 32'h4);
    pushExp("adelif_badvaddr", 32'hBFC0_0102);
    #1;
    chk(bus.excepttypeM);
    edgeSample();
    chk(bus.rdata);

    // Count write and wrap
    mtc0(5'd9, 32'hFFFF_FFFF);
    bus.raddr = 5'd9;
    pushExp("count_write", 32'hFFFF_FFFF);
    #1;
    chk(bus.rdata);
    @(negedge clk);
    clearIn();
    bus.raddr = 5'd9;
    pushExp("count_wrap", 32'h0);
    edgeSample();
    edgeSample();
    chk(bus.rdata);

    // 4: timer interrupt
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    mtc0(5'd12, 32'h0000_8001);
    pushExp("t4_status", 32'h0040_8001);
    chk(bus.status_o);
    mtc0(5'd11, 32'd5);
    @(negedge clk);
    clearIn();
    for (int i = 0; i < 40 && !bus.cause_o[15]; i++) @(negedge clk);
    pushExp("t4_ip7_set", 32'h1);
    chk(32'(bus.cause_o[15]));
    bus.pcM = 32'hBFC0_0100;
    pushExp("t4_exc", 32'h1);
    pushExp("t4_flush", 32'h1);
    pushExp("t4_exl", 32'h1);
    pushExp("t4_exccode", 32'h0);
    pushExp("t4_epc", 32'hBFC0_0100);
    #1;
    chk(bus.excepttypeM);
    chk(32'(bus.flushM));
    edgeSample();
    chk(32'(bus.status_o[1]));
    chk(32'(bus.cause_o[6:2]));
    chk(bus.epc_o);
    mtc0(5'd11, 32'd0);
    @(negedge clk);
    clearIn();
    pushExp("t4_ip7_clear", 32'h0);
    edgeSample();
    chk(32'(bus.cause_o[15]));

    // 5: ERET returns to EPC, clears EXL, drops same-cycle MTC0
    mtc0(5'd14, 32'hBFC0_0500);
    @(negedge clk);
    clearIn();
    bus.eretM  = 1'b1;
    bus.pcM    = 32'hBFC0_0600;
    bus.we_cp0 = 1'b1;
    bus.waddr  = 5'd14;
    bus.wdata  = 32'h1234_5678;
    pushExp("t5_newpc", 32'hBFC0_0500);
    pushExp("t5_flush", 32'h1);
    pushExp("t5_exc", 32'hE);
    pushExp("t5_exl", 32'h0);
    pushExp("t5_epc", 32'hBFC0_0500);
    #1;
    chk(bus.newpcM);
    chk(32'(bus.flushM));
    chk(bus.excepttypeM);
    edgeSample();
    chk(32'(bus.status_o[1]));
    chk(bus.epc_o);

    // 6: stall suppresses everything, bubble ignores flags, async reset
    @(negedge clk);
    clearIn();
    bus.stallM = 1'b1;
    bus.adelM  = 1'b1;
    bus.pcM    = 32'hBFC0_0700;
    bus.addrM  = 32'h4000_0000;
    bus.raddr  = 5'd8;
    pushExp("t6_stall_flush", 32'h0);
    pushExp("t6_stall_epc", 32'hBFC0_0500);
    pushExp("t6_stall_badvaddr", 32'h0);
    pushExp("t6_stall_exl", 32'h0);
    #1;
    chk(32'(bus.flushM));
    edgeSample();
    chk(bus.epc_o);
    chk(bus.rdata);
    chk(32'(bus.status_o[1]));
    @(negedge clk);
    clearIn();
    bus.adelM = 1'b1;
    bus.addrM = 32'h4000_0000;
    pushExp("t6_bubble_exc", 32'h0);
    #1;
    chk(bus.excepttypeM);
    @(negedge clk);
    clearIn();
    #2;
    resetn = 1'b0;
    pushExp("t6_rst_status", 32'h0040_0000);
    pushExp("t6_rst_epc", 32'h0);
    #1;
    chk(bus.status_o);
    chk(bus.epc_o);
    resetn = 1'b1;

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
